// File: rtl/riscv_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : riscv_ctrl_pkg
// Brief  : Shared opcode constants and controller state encoding for the
//          5-stage pipeline sequencing logic.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BEQ    = 7'b1100011;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] NOP    = 7'b0000000;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
//------------------------------------------------------------------------------
// Module : load_use_detect
// Brief  : Combinational load-use hazard flag: decodes which sources the ID
//          instruction reads and compares them against the loading ID/EX rd.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_use_detect
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic w_use_rs1;
    logic w_use_rs2;

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (id_opcode)
            R_TYPE, SW, BEQ: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            LW, ADDI: begin
                w_use_rs1 = 1'b1;
            end
            default: begin
                w_use_rs1 = 1'b0;
                w_use_rs2 = 1'b0;
            end
        endcase
    end

    // x0 is hard-wired to zero, so a load into it can never create a dependency
    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((w_use_rs1 && (id_rs1 == ex_rd)) ||
                     (w_use_rs2 && (id_rs2 == ex_rd)));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : pipe_hazard_ctrl
// Brief  : Pipeline sequencing controller: stage enables/flushes, PC source,
//          data-memory handshake with timeout watchdog. Optional perf counters
//          enabled by defining PIPE_PERF_CNT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_src,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic             err
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255) || (CNT_W < 1)) begin : g_param_check
        $error("pipe_hazard_ctrl: illegal MEM_TIMEOUT or CNT_W");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic                w_mem_access;
    logic                w_hazard;
    logic                w_go;
    logic                w_flush_fire;

    assign w_mem_access = mem_mem_read | mem_mem_write;

    load_use_detect u_load_use_detect (
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        w_go         = 1'b0;
        dmem_req     = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = 1'b0;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    dmem_req = w_mem_access;
                    if (w_mem_access && !dmem_ready) begin
                        w_state_nxt = MEM_WAIT;
                        w_wcnt_nxt  = WCNT_W'(1);
                    end else begin
                        w_go = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        w_go        = 1'b1;
                        w_state_nxt = RUN;
                        w_wcnt_nxt  = '0;
                    end else if (r_wcnt == WCNT_W'(MEM_TIMEOUT)) begin
                        w_state_nxt = ERROR;
                    end else begin
                        w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                    end
                end
                ERROR: begin
                    w_state_nxt = ERROR;
                end
                default: begin
                    w_state_nxt = ERROR;
                end
            endcase

            // Pipeline advances: branch squash outranks the load-use stall
            if (w_go) begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                if (mem_branch_taken) begin
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (w_hazard) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    assign w_flush_fire = w_go & mem_branch_taken;
    assign err          = (r_state == ERROR);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_en && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush_fire && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int CNT_W = 8;

    // Expected vector bit order:
    // pc_en if_id_en id_ex_en ex_mem_en mem_wb_en | if_id_fl id_ex_fl ex_mem_fl | pc_src dmem_req err
    localparam logic [10:0] E_RST    = 11'b00000_111_000;
    localparam logic [10:0] E_RSTERR = 11'b00000_111_001;
    localparam logic [10:0] E_NORM   = 11'b11111_000_000;
    localparam logic [10:0] E_STALL  = 11'b00111_010_000;
    localparam logic [10:0] E_BR     = 11'b11111_111_100;
    localparam logic [10:0] E_BRMEM  = 11'b11111_111_110;
    localparam logic [10:0] E_WAIT   = 11'b00000_000_010;
    localparam logic [10:0] E_MEMGO  = 11'b11111_000_010;
    localparam logic [10:0] E_ERR    = 11'b00000_000_001;

    logic       clk;
    logic       reset;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_branch_taken, mem_mem_read, mem_mem_write, dmem_ready;
    logic       dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, pc_src, err;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_opcode        (id_opcode),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .mem_branch_taken (mem_branch_taken),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .dmem_ready       (dmem_ready),
        .dmem_req         (dmem_req),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_en        (mem_wb_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .pc_src           (pc_src),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles     (stall_cycles),
        .flush_events     (flush_events),
`endif
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic exmr, input logic [4:0] exrd,
                         input logic br, input logic mr, input logic mw, input logic rdy);
        reset            = rst;
        id_opcode        = op;
        id_rs1           = rs1;
        id_rs2           = rs2;
        ex_mem_read      = exmr;
        ex_rd            = exrd;
        mem_branch_taken = br;
        mem_mem_read     = mr;
        mem_mem_write    = mw;
        dmem_ready       = rdy;
    endtask

    task automatic idle();
        drive(1'b0, NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expectation for the current inputs, compare mid-cycle, then clock.
    task automatic step(input logic [10:0] exp, input string tag);
        logic [10:0] obs;
        logic [10:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_src, dmem_req, err};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        step(E_RST, "reset_hold");
        idle();
        step(E_NORM, "idle_after_reset");

        // Load-use: exactly one stall cycle then bubble in EX
        drive(1'b0, R_TYPE, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_STALL, "loaduse_rtype_rs2");
        drive(1'b0, R_TYPE, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_NORM, "loaduse_released");

        // No false stalls
        drive(1'b0, R_TYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_NORM, "nostall_rd_x0");
        drive(1'b0, ADDI, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_NORM, "nostall_addi_rs2");
        drive(1'b0, NOP, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_NORM, "nostall_nop");
        drive(1'b0, R_TYPE, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_NORM, "nostall_no_memread");
        drive(1'b0, LW, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_STALL, "loaduse_lw_rs1");
        drive(1'b0, BEQ, 5'd4, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step(E_STALL, "loaduse_beq_rs2");

        // Branch overrides a simultaneous load-use hazard
        drive(1'b0, R_TYPE, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(E_BR, "branch_over_hazard");
        idle();
        step(E_NORM, "after_branch");
`ifdef PIPE_PERF_CNT_EN
        checks++;
        assert (stall_cycles === 8'd3) else begin
            errors++;
            $error("FAIL stall_cycles observed=%0d expected=%0d", stall_cycles, 3);
        end
        checks++;
        assert (flush_events === 8'd1) else begin
            errors++;
            $error("FAIL flush_events observed=%0d expected=%0d", flush_events, 1);
        end
`endif

        // Three wait states then completion
        drive(1'b0, NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(E_WAIT, "wait_1");
        step(E_WAIT, "wait_2");
        step(E_WAIT, "wait_3");
        dmem_ready = 1'b1;
        step(E_MEMGO, "wait_done");
        idle();
        step(E_NORM, "wait_back_to_run");

        // Zero-wait store
        drive(1'b0, NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(E_MEMGO, "zero_wait_store");

        // Memory wait outranks branch, branch applies once ready
        drive(1'b0, NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(E_WAIT, "wait_before_branch");
        dmem_ready = 1'b1;
        step(E_BRMEM, "branch_after_wait");

        // Timeout: RUN stall + wcnt 1..4 in MEM_WAIT, then sticky ERROR
        drive(1'b0, NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(E_WAIT, "to_run_cycle");
        step(E_WAIT, "to_wcnt1");
        step(E_WAIT, "to_wcnt2");
        step(E_WAIT, "to_wcnt3");
        step(E_WAIT, "to_wcnt4");
        step(E_ERR, "error_entered");
        dmem_ready = 1'b1;
        step(E_ERR, "error_sticky_ready");
        idle();
        step(E_ERR, "error_sticky_idle");
        reset = 1'b1;
        step(E_RSTERR, "reset_from_error");
        reset = 1'b0;
        step(E_NORM, "run_after_error_reset");

        // Reset during the second MEM_WAIT cycle
        drive(1'b0, NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(E_WAIT, "midwait_run");
        step(E_WAIT, "midwait_1");
        reset = 1'b1;
        step(E_RST, "midwait_reset");
        checks++;
        assert (dut.r_wcnt === '0) else begin
            errors++;
            $error("FAIL wcnt_after_reset observed=%0d expected=0", dut.r_wcnt);
        end
        checks++;
        assert (dut.r_state === RUN) else begin
            errors++;
            $error("FAIL state_after_reset observed=%0d expected=%0d", dut.r_state, RUN);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        assert (stall_cycles === 8'd0) else begin
            errors++;
            $error("FAIL stall_cycles_reset observed=%0d expected=0", stall_cycles);
        end
`endif
        idle();
        step(E_NORM, "run_after_midwait_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
